// File: rtl/cmn_pwm_ctrl.sv
// Sequencing/supervision front-end for cmn_pwm: double-buffered duty parameters
// applied on PWM period boundaries, plus arm/run/fault-retry/lockout enable control.
//
// state   | meaning
// IDLE    | enables off, waiting for a host enable request
// ARMING  | waiting for a PWM period start, sync timeout running
// RUN     | enables follow the host requests
// FAULT   | over-current back-off, counting pulse_200us before retry
// LOCKOUT | retries exhausted or sync lost, waits for clr_fault
module cmn_pwm_ctrl #(
  parameter int PWM_WIDTH           = 10,
  parameter int DUTY_MAX            = 1000,
  parameter int FAULT_RETRY_PULSES  = 5,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_TIMEOUT_PULSES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_200us,
  input  logic                 start_pwm_period,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_sel,
  input  logic [PWM_WIDTH-1:0] cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_pending,
  input  logic                 host_mot_en,
  input  logic                 host_brk_en,
  input  logic                 mot_over_curr,
  input  logic                 brk_over_curr,
  input  logic                 clr_fault,
  output logic [PWM_WIDTH-1:0] mot_pwm_param01,
  output logic [PWM_WIDTH-1:0] mot_pwm_param23,
  output logic [PWM_WIDTH-1:0] mot_pwm_param45,
  output logic [PWM_WIDTH-1:0] brk_pwm_param,
  output logic                 mot_en_out,
  output logic                 brk_en_out,
  output logic [2:0]           ctrl_state,
  output logic [2:0]           fault_flags
);

  localparam int FW = $clog2(FAULT_RETRY_PULSES + 1);
  localparam int SW = $clog2(SYNC_TIMEOUT_PULSES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [PWM_WIDTH-1:0] DUTY_LIM = PWM_WIDTH'(DUTY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMING  = 3'd1,
    ST_RUN     = 3'd2,
    ST_FAULT   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t               state;
  logic [PWM_WIDTH-1:0] stg [4];
  logic                 pend_defer;
  logic                 pend_imm;
  logic [FW-1:0]        fault_cnt;
  logic [SW-1:0]        sync_cnt;
  logic [RW-1:0]        retry_cnt;

  logic [PWM_WIDTH-1:0] wr_val;
  logic                 sync_state;
  logic                 any_oc;
  logic                 host_en;

  assign wr_val      = (cfg_data > DUTY_LIM) ? DUTY_LIM : cfg_data;
  assign sync_state  = (state == ST_ARMING) || (state == ST_RUN);
  assign any_oc      = mot_over_curr | brk_over_curr;
  assign host_en     = host_mot_en | host_brk_en;
  assign cfg_pending = pend_defer | pend_imm;
  assign ctrl_state  = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      for (int i = 0; i < 4; i++) stg[i] <= '0;
      pend_defer      <= 1'b0;
      pend_imm        <= 1'b0;
      fault_cnt       <= '0;
      sync_cnt        <= '0;
      retry_cnt       <= '0;
      mot_pwm_param01 <= '0;
      mot_pwm_param23 <= '0;
      mot_pwm_param45 <= '0;
      brk_pwm_param   <= '0;
      mot_en_out      <= 1'b0;
      brk_en_out      <= 1'b0;
      fault_flags     <= '0;
    end else begin
      if (cfg_wr) stg[cfg_sel] <= wr_val;

      // A deferred commit that outlives ARMING/RUN is applied at once instead of lost.
      pend_imm <= 1'b0;
      if (pend_defer) begin
        if (start_pwm_period || !sync_state) begin
          mot_pwm_param01 <= stg[0];
          mot_pwm_param23 <= stg[1];
          mot_pwm_param45 <= stg[2];
          brk_pwm_param   <= stg[3];
          pend_defer      <= 1'b0;
        end
      end else if (cfg_commit && !pend_imm) begin
        if (sync_state) begin
          pend_defer <= 1'b1;
        end else begin
          mot_pwm_param01 <= stg[0];
          mot_pwm_param23 <= stg[1];
          mot_pwm_param45 <= stg[2];
          brk_pwm_param   <= stg[3];
          pend_imm        <= 1'b1;
        end
      end

      mot_en_out <= 1'b0;
      brk_en_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_en) begin
            state    <= ST_ARMING;
            sync_cnt <= '0;
          end
        end
        ST_ARMING: begin
          if (start_pwm_period) begin
            state <= ST_RUN;
          end else if (pulse_200us) begin
            if (int'(sync_cnt) >= SYNC_TIMEOUT_PULSES - 1) begin
              state          <= ST_LOCKOUT;
              fault_flags[2] <= 1'b1;
            end else begin
              sync_cnt <= sync_cnt + SW'(1);
            end
          end else if (!host_en) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (any_oc) begin
            state          <= ST_FAULT;
            fault_cnt      <= '0;
            fault_flags[0] <= fault_flags[0] | mot_over_curr;
            fault_flags[1] <= fault_flags[1] | brk_over_curr;
            if (int'(retry_cnt) <= MAX_RETRIES) retry_cnt <= retry_cnt + RW'(1);
          end else if (!host_en) begin
            state       <= ST_IDLE;
            retry_cnt   <= '0;
            fault_flags <= '0;
          end else begin
            mot_en_out <= host_mot_en;
            brk_en_out <= host_brk_en;
          end
        end
        ST_FAULT: begin
          fault_flags[0] <= fault_flags[0] | mot_over_curr;
          fault_flags[1] <= fault_flags[1] | brk_over_curr;
          if (pulse_200us) begin
            if (int'(fault_cnt) >= FAULT_RETRY_PULSES - 1) begin
              // retry_cnt counts faults, so MAX_RETRIES retries means retry while <= MAX_RETRIES
              if (int'(retry_cnt) <= MAX_RETRIES) begin
                state    <= ST_ARMING;
                sync_cnt <= '0;
              end else begin
                state <= ST_LOCKOUT;
              end
            end else begin
              fault_cnt <= fault_cnt + FW'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          if (clr_fault && !host_en) begin
            state       <= ST_IDLE;
            retry_cnt   <= '0;
            fault_flags <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmn_pwm_ctrl.sv
// Self-checking bench for cmn_pwm_ctrl: expectations are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_cmn_pwm_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         pulse_200us, start_pwm_period, cfg_wr, cfg_commit, cfg_pending;
  logic [1:0]   cfg_sel;
  logic [W-1:0] cfg_data;
  logic         host_mot_en, host_brk_en, mot_over_curr, brk_over_curr, clr_fault;
  logic [W-1:0] mot01, mot23, mot45, brk;
  logic         mot_en_out, brk_en_out;
  logic [2:0]   ctrl_state, fault_flags;

  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  cmn_pwm_ctrl dut (
    .clk(clk), .reset(reset), .pulse_200us(pulse_200us), .start_pwm_period(start_pwm_period),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .host_mot_en(host_mot_en), .host_brk_en(host_brk_en),
    .mot_over_curr(mot_over_curr), .brk_over_curr(brk_over_curr), .clr_fault(clr_fault),
    .mot_pwm_param01(mot01), .mot_pwm_param23(mot23), .mot_pwm_param45(mot45),
    .brk_pwm_param(brk), .mot_en_out(mot_en_out), .brk_en_out(brk_en_out),
    .ctrl_state(ctrl_state), .fault_flags(fault_flags)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    pulse_200us = 1'b1; tick(); pulse_200us = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL reset_state got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL reset_pending got %0b exp %0b", cfg_pending, e[0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL reset_mot01 got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if ({mot_en_out, brk_en_out, fault_flags} !== e[4:0]) $display("FAIL reset_en_flags got %0h exp %0h", {mot_en_out, brk_en_out, fault_flags}, e[4:0]); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_commit_idle();
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_data = 10'h3FF; tick();
    cfg_sel = 2'd3; cfg_data = 10'h020; tick();
    cfg_wr = 1'b0;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL idle_precommit_mot01 got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    cfg_commit = 1'b1;
    exp_q.push_back(32'd1000); exp_q.push_back(32'h020); exp_q.push_back(32'd1);
    tick();
    cfg_commit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL idle_sat_mot01 got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (brk !== e[W-1:0]) $display("FAIL idle_brk got %0h exp %0h", brk, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL idle_pending_pulse got %0b exp %0b", cfg_pending, e[0]); else passed++;
    exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL idle_pending_clear got %0b exp %0b", cfg_pending, e[0]); else passed++;
  endtask

  task automatic test_arm_run();
    host_mot_en = 1'b1;
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL arm_state got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    start_pwm_period = 1'b1;
    exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    tick();
    start_pwm_period = 1'b0;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL run_state got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot_en_out !== e[0]) $display("FAIL run_entry_mot_en got %0b exp %0b", mot_en_out, e[0]); else passed++;
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); total++;
    if (mot_en_out !== e[0]) $display("FAIL run_mot_en got %0b exp %0b", mot_en_out, e[0]); else passed++;
  endtask

  task automatic test_commit_run();
    int bad;
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_data = 10'h100; tick();
    cfg_sel = 2'd3; cfg_data = 10'h050; tick();
    cfg_wr = 1'b0;
    cfg_commit = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1000);
    tick();
    cfg_commit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL run_commit_pending got %0b exp %0b", cfg_pending, e[0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL run_commit_hold got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (cfg_pending !== 1'b1 || mot01 !== 10'd1000) bad++;
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); total++;
    if (bad !== int'(e)) $display("FAIL run_pending_hold_cycles got %0d exp %0d", bad, e); else passed++;
    start_pwm_period = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h050); exp_q.push_back(32'd0);
    tick();
    start_pwm_period = 1'b0;
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL run_xfer_mot01 got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (brk !== e[W-1:0]) $display("FAIL run_xfer_brk got %0h exp %0h", brk, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL run_xfer_pending got %0b exp %0b", cfg_pending, e[0]); else passed++;
  endtask

  task automatic test_same_cycle();
    cfg_wr = 1'b1; cfg_sel = 2'd1; cfg_data = 10'h123; tick();
    cfg_wr = 1'b0;
    cfg_commit = 1'b1; start_pwm_period = 1'b1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    tick();
    cfg_commit = 1'b0; start_pwm_period = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL same_cycle_pending got %0b exp %0b", cfg_pending, e[0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot23 !== e[W-1:0]) $display("FAIL same_cycle_no_xfer got %0h exp %0h", mot23, e[W-1:0]); else passed++;
    tick(3);
    start_pwm_period = 1'b1;
    exp_q.push_back(32'h123); exp_q.push_back(32'd0);
    tick();
    start_pwm_period = 1'b0;
    e = exp_q.pop_front(); total++;
    if (mot23 !== e[W-1:0]) $display("FAIL same_cycle_next_xfer got %0h exp %0h", mot23, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL same_cycle_pending_clr got %0b exp %0b", cfg_pending, e[0]); else passed++;
  endtask

  task automatic test_fault_retry();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        start_pwm_period = 1'b1; tick(); start_pwm_period = 1'b0; tick();
      end
      mot_over_curr = 1'b1;
      exp_q.push_back(32'd3); exp_q.push_back(32'd0); exp_q.push_back(32'b001);
      tick();
      mot_over_curr = 1'b0;
      e = exp_q.pop_front(); total++;
      if (ctrl_state !== e[2:0]) $display("FAIL fault%0d_state got %0d exp %0d", k, ctrl_state, e[2:0]); else passed++;
      e = exp_q.pop_front(); total++;
      if (mot_en_out !== e[0]) $display("FAIL fault%0d_mot_en got %0b exp %0b", k, mot_en_out, e[0]); else passed++;
      e = exp_q.pop_front(); total++;
      if (fault_flags !== e[2:0]) $display("FAIL fault%0d_flags got %0b exp %0b", k, fault_flags, e[2:0]); else passed++;
      for (int p = 0; p < 4; p++) pulse_tick();
      exp_q.push_back(32'd3);
      e = exp_q.pop_front(); total++;
      if (ctrl_state !== e[2:0]) $display("FAIL fault%0d_wait got %0d exp %0d", k, ctrl_state, e[2:0]); else passed++;
      exp_q.push_back((k <= 3) ? 32'd1 : 32'd4);
      pulse_tick();
      e = exp_q.pop_front(); total++;
      if (ctrl_state !== e[2:0]) $display("FAIL fault%0d_exit got %0d exp %0d", k, ctrl_state, e[2:0]); else passed++;
    end
    clr_fault = 1'b1;
    exp_q.push_back(32'd4);
    tick();
    clr_fault = 1'b0;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL lockout_hold got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    host_mot_en = 1'b0; clr_fault = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    clr_fault = 1'b0;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL lockout_clear_state got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (fault_flags !== e[2:0]) $display("FAIL lockout_clear_flags got %0b exp %0b", fault_flags, e[2:0]); else passed++;
  endtask

  task automatic test_sync_timeout();
    host_brk_en = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) pulse_tick();
    exp_q.push_back(32'd1);
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL sync_wait got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    exp_q.push_back(32'd4); exp_q.push_back(32'b100);
    pulse_tick();
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL sync_lockout got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (fault_flags !== e[2:0]) $display("FAIL sync_flags got %0b exp %0b", fault_flags, e[2:0]); else passed++;
    host_brk_en = 1'b0; clr_fault = 1'b1;
    exp_q.push_back(32'd0);
    tick();
    clr_fault = 1'b0;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL sync_clear got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
  endtask

  task automatic test_brk_fault_disable();
    host_mot_en = 1'b1; host_brk_en = 1'b1;
    tick();
    start_pwm_period = 1'b1; tick(); start_pwm_period = 1'b0;
    exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); total++;
    if (brk_en_out !== e[0]) $display("FAIL brk_en_run got %0b exp %0b", brk_en_out, e[0]); else passed++;
    brk_over_curr = 1'b1;
    exp_q.push_back(32'b010); exp_q.push_back(32'd0);
    tick();
    brk_over_curr = 1'b0;
    e = exp_q.pop_front(); total++;
    if (fault_flags !== e[2:0]) $display("FAIL brk_fault_flags got %0b exp %0b", fault_flags, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (brk_en_out !== e[0]) $display("FAIL brk_fault_en got %0b exp %0b", brk_en_out, e[0]); else passed++;
    for (int p = 0; p < 5; p++) pulse_tick();
    start_pwm_period = 1'b1;
    exp_q.push_back(32'd2);
    tick();
    start_pwm_period = 1'b0;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL brk_retry_run got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    host_mot_en = 1'b0; host_brk_en = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL disable_idle got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (fault_flags !== e[2:0]) $display("FAIL disable_flags got %0b exp %0b", fault_flags, e[2:0]); else passed++;
  endtask

  task automatic test_reset_pending();
    host_mot_en = 1'b1;
    tick();
    start_pwm_period = 1'b1; tick(); start_pwm_period = 1'b0;
    cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_data = 10'h077; tick();
    cfg_wr = 1'b0; cfg_commit = 1'b1;
    exp_q.push_back(32'd1);
    tick();
    cfg_commit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL rstpend_pending got %0b exp %0b", cfg_pending, e[0]); else passed++;
    reset = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); total++;
    if (cfg_pending !== e[0]) $display("FAIL rstpend_pending_clr got %0b exp %0b", cfg_pending, e[0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot01 !== e[W-1:0]) $display("FAIL rstpend_mot01 got %0h exp %0h", mot01, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (mot23 !== e[W-1:0]) $display("FAIL rstpend_mot23 got %0h exp %0h", mot23, e[W-1:0]); else passed++;
    e = exp_q.pop_front(); total++;
    if (ctrl_state !== e[2:0]) $display("FAIL rstpend_state got %0d exp %0d", ctrl_state, e[2:0]); else passed++;
    reset = 1'b1; host_mot_en = 1'b0;
    tick();
    cfg_commit = 1'b1;
    exp_q.push_back(32'd0);
    tick();
    cfg_commit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (mot45 !== e[W-1:0]) $display("FAIL rstpend_staging_clr got %0h exp %0h", mot45, e[W-1:0]); else passed++;
  endtask

  initial begin
    reset = 1'b0; pulse_200us = 1'b0; start_pwm_period = 1'b0; cfg_wr = 1'b0;
    cfg_sel = 2'd0; cfg_data = '0; cfg_commit = 1'b0; host_mot_en = 1'b0;
    host_brk_en = 1'b0; mot_over_curr = 1'b0; brk_over_curr = 1'b0; clr_fault = 1'b0;
    test_reset();
    test_commit_idle();
    test_arm_run();
    test_commit_run();
    test_same_cycle();
    test_fault_retry();
    test_sync_timeout();
    test_brk_fault_disable();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
